// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes and a
// registered one-cycle expiry pulse; the count shows N..0, expiring on tick N+1.
module countdown_timer #(
  parameter int Limit = 16,
  localparam int Width = $clog2(Limit)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [Width-1:0] load_value_i,
  input  logic             periodic_i,
  input  logic             tick_i,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic [Width-1:0] value_o,
  output logic             busy_o,
  output logic             expire_o,
  output logic             will_underflow_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [Width:0] MaxLoad = (Width + 1)'(Limit - 1);

  state_t           state_q, state_d;
  logic [Width-1:0] value_q, value_d;
  logic [Width-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             expire_q, expire_d;
  logic             tk;

  // Compared one bit wider so the clamp stays a real comparison when Limit is 2**Width.
  function automatic logic [Width-1:0] clamp_load(input logic [Width-1:0] v);
    logic [Width:0] ext;
    ext = {1'b0, v};
    if (ext > MaxLoad) return MaxLoad[Width-1:0];
    return v;
  endfunction

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    expire_d   = 1'b0;

    tk = (state_q == RUN) && tick_i && !pause_i && !abort_i;

    if (abort_i) begin
      // Abort in IDLE is a no-op; in RUN it cancels without an expiry pulse.
      if (state_q == RUN) begin
        state_d = IDLE;
        value_d = '0;
      end
    end else if (state_q == RUN) begin
      if (tk) begin
        if (value_q == '0) begin
          expire_d = 1'b1;
          if (periodic_q) value_d = reload_q;
          else            state_d = IDLE;
        end else begin
          value_d = value_q - Width'(1);
        end
      end
    end else if (load_valid_i) begin
      value_d    = clamp_load(load_value_i);
      reload_d   = clamp_load(load_value_i);
      periodic_d = periodic_i;
      state_d    = RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      value_q    <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      expire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
    end
  end

  assign load_ready_o     = (state_q == IDLE) && !abort_i;
  assign busy_o           = (state_q == RUN);
  assign expire_o         = expire_q;
  assign value_o          = value_q;
  assign will_underflow_o = tk && (value_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: Limit=16 and Limit=10 instances share stimulus and are
// checked against a ticks-remaining model, with directed scenarios then random traffic.
module tb_countdown_timer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load_valid, periodic, tick, pause, abort;
  logic [3:0] load_value;
  logic [1:0] ready, busy, expire, wu;
  logic [3:0] val [2];

  countdown_timer #(.Limit(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .load_valid_i(load_valid), .load_ready_o(ready[0]),
    .load_value_i(load_value), .periodic_i(periodic), .tick_i(tick), .pause_i(pause),
    .abort_i(abort), .value_o(val[0]), .busy_o(busy[0]), .expire_o(expire[0]),
    .will_underflow_o(wu[0]));

  countdown_timer #(.Limit(10)) dut10 (
    .clk_i(clk), .rst_i(rst), .load_valid_i(load_valid), .load_ready_o(ready[1]),
    .load_value_i(load_value), .periodic_i(periodic), .tick_i(tick), .pause_i(pause),
    .abort_i(abort), .value_o(val[1]), .busy_o(busy[1]), .expire_o(expire[1]),
    .will_underflow_o(wu[1]));

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  // Model: a running timer needs m_left more effective ticks to expire; an idle timer reads 0.
  int m_left [2];
  int m_n    [2];
  bit m_run  [2];
  bit m_per  [2];
  bit m_exp  [2];

  function automatic int lim(input int i);
    return (i == 0) ? 16 : 10;
  endfunction

  function automatic bit eff_tick(input int i);
    return m_run[i] && tick && !pause && !abort;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_update(input int i);
    bit tk;
    tk = eff_tick(i);
    m_exp[i] = 1'b0;
    if (rst) begin
      m_run[i] = 0; m_per[i] = 0; m_n[i] = 0; m_left[i] = 0;
    end else if (abort) begin
      m_run[i] = 0;
    end else if (m_run[i]) begin
      if (tk) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_exp[i] = 1'b1;
          if (m_per[i]) m_left[i] = m_n[i] + 1;
          else          m_run[i] = 0;
        end
      end
    end else if (load_valid) begin
      m_n[i]    = (int'(load_value) < lim(i)) ? int'(load_value) : lim(i) - 1;
      m_left[i] = m_n[i] + 1;
      m_per[i]  = periodic;
      m_run[i]  = 1;
    end
  endtask

  // Inputs are set just after a rising edge; comb outputs are checked mid-cycle,
  // registered outputs one time unit after the next rising edge.
  task automatic step();
    #3;
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready[%0d]", i), ready[i], !m_run[i] && !abort);
        chk($sformatf("will_uf[%0d]", i), wu[i], eff_tick(i) && (m_left[i] == 1));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_update(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("value[%0d]", i), val[i], m_run[i] ? m_left[i] - 1 : 0);
      chk($sformatf("busy[%0d]", i), busy[i], m_run[i]);
      chk($sformatf("expire[%0d]", i), expire[i], m_exp[i]);
    end
  endtask

  initial begin
    int nexp;
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; m_n[i] = 0; m_run[i] = 0; m_per[i] = 0; m_exp[i] = 0;
    end
    rst = 1; load_valid = 0; load_value = 0; periodic = 0; tick = 0; pause = 0; abort = 0;
    @(posedge clk); #1;
    step();
    chk("rst_value", val[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_expire", expire[0], 0);
    rst = 0; armed = 1;
    #2 chk("rst_ready_after", ready[0], 1);

    // One-shot N=3 with a tick every cycle.
    load_valid = 1; load_value = 3; periodic = 0; tick = 1;
    step();
    chk("t1_load", val[0], 3);
    load_valid = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_count", val[0], 2 - k);
    end
    chk("t1_no_early_expire", expire[0], 0);
    step();
    chk("t1_expire", expire[0], 1);
    chk("t1_busy_off", busy[0], 0);
    #2 chk("t1_ready", ready[0], 1);
    tick = 0;
    step();
    chk("t1_pulse_len", expire[0], 0);

    // Periodic N=2, tick every other cycle: expiry every 6 cycles.
    load_valid = 1; load_value = 2; periodic = 1;
    step();
    load_valid = 0;
    nexp = 0;
    for (int k = 0; k < 12; k++) begin
      tick = (k % 2 == 0);
      step();
      nexp += int'(expire[0]);
    end
    chk("t2_expire_count", nexp, 2);
    chk("t2_busy", busy[0], 1);
    chk("t2_reloaded", val[0], 2);
    abort = 1; tick = 0;
    step();
    abort = 0;

    // Pause for 4 cycles at value 3.
    load_valid = 1; load_value = 5; periodic = 0; tick = 1;
    step();
    load_valid = 0;
    step(); step();
    chk("t3_at3", val[0], 3);
    pause = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_hold", val[0], 3);
    end
    pause = 0;
    for (int k = 0; k < 3; k++) step();
    chk("t3_at0", val[0], 0);
    step();
    chk("t3_expire", expire[0], 1);

    // Abort at value 0 with a tick present.
    load_valid = 1; load_value = 1; periodic = 0; tick = 1;
    step();
    load_valid = 0;
    step();
    chk("t4_at0", val[0], 0);
    abort = 1;
    step();
    chk("t4_no_expire", expire[0], 0);
    chk("t4_idle", busy[0], 0);
    load_valid = 1; load_value = 7;
    #2 chk("t4_ready_low", ready[0], 0);
    step();
    chk("t4_no_load", busy[0], 0);
    chk("t4_value", val[0], 0);
    abort = 0; load_valid = 0; tick = 0;

    // Clamp on the Limit=10 instance, then a zero load.
    load_valid = 1; load_value = 15;
    step();
    chk("t5_clamp10", val[1], 9);
    chk("t5_noclamp16", val[0], 15);
    load_valid = 0; abort = 1;
    step();
    abort = 0;
    load_valid = 1; load_value = 0;
    step();
    load_valid = 0; tick = 1;
    #2 chk("t5_zero_wu", wu[1], 1);
    step();
    chk("t5_zero_expire", expire[1], 1);
    load_valid = 1; load_value = 7;
    step();
    load_valid = 0;
    step(); step();
    rst = 1;
    step();
    chk("t5_rst_value", val[0], 0);
    chk("t5_rst_busy", busy[0], 0);
    chk("t5_rst_expire", expire[0], 0);
    rst = 0; tick = 0;
    #2 chk("t5_rst_ready", ready[0], 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom_range(63) == 0);
      abort      = ($urandom_range(15) == 0);
      pause      = ($urandom_range(3) == 0);
      tick       = $urandom_range(1);
      load_valid = ($urandom_range(2) == 0);
      load_value = 4'($urandom_range(15));
      periodic   = $urandom_range(1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
